// File: rtl/master_alu_if.sv
// Operand/result bundle between the decode stage and the master CPU execute stage.
interface master_alu_if;
    logic signed [31:0] Reg1;
    logic signed [31:0] Reg2;
    logic        [4:0]  IV_ShftRor;
    logic        [15:0] IV_Mov;
    logic        [3:0]  OpCode;
    logic        [3:0]  Cond;
    logic               S;
    logic signed [31:0] Result;
    logic        [3:0]  Flag;
    logic               Write_en;
    logic               memory_enable;

    modport master (
        output Reg1, Reg2, IV_ShftRor, IV_Mov, OpCode, Cond, S,
        input  Result, Flag, Write_en, memory_enable
    );

    modport slave (
        input  Reg1, Reg2, IV_ShftRor, IV_Mov, OpCode, Cond, S,
        output Result, Flag, Write_en, memory_enable
    );
endinterface

// File: rtl/master_alu.sv
// Execute stage of the master CPU: conditional ARM-style ALU with an NZCV
// flag register. Every output is registered, one cycle after the operands.
module master_alu (
    input  logic         Clk,
    input  logic         Reset,
    master_alu_if.slave  bus
);
    typedef enum logic [3:0] {
        OP_ADD = 4'h0, OP_SUB = 4'h1, OP_MUL = 4'h2, OP_ORR = 4'h3,
        OP_AND = 4'h4, OP_EOR = 4'h5, OP_MOV = 4'h6, OP_LSR = 4'h7,
        OP_LSL = 4'h8, OP_ROR = 4'h9, OP_CMP = 4'hA, OP_ASR = 4'hB,
        OP_LDR = 4'hC, OP_STR = 4'hD
    } op_t;

    logic [31:0] a, b;
    logic [4:0]  iv;
    logic        fn, fz, fc, fv;
    logic        pass;
    logic [32:0] sum, diff;
    logic [4:0]  rsh_idx, lsh_idx;
    logic [31:0] val;
    logic        c_n, v_n;
    logic        wr_op, mem_op, flag_op;
    logic [31:0] res_n;
    logic [3:0]  flag_n;
    logic        we_n, me_n;

    assign a  = bus.Reg1;
    assign b  = bus.Reg2;
    assign iv = bus.IV_ShftRor;
    assign {fn, fz, fc, fv} = bus.Flag;

    // Condition check against the currently held flags.
    always_comb begin
        pass = 1'b0;
        case (bus.Cond)
            4'h0: pass = fz;
            4'h1: pass = !fz;
            4'h2: pass = fc;
            4'h3: pass = !fc;
            4'h4: pass = fn;
            4'h5: pass = !fn;
            4'h6: pass = fv;
            4'h7: pass = !fv;
            4'h8: pass = fc && !fz;
            4'h9: pass = !fc || fz;
            4'hA: pass = (fn == fv);
            4'hB: pass = (fn != fv);
            4'hC: pass = !fz && (fn == fv);
            4'hD: pass = fz || (fn != fv);
            4'hE: pass = 1'b1;
            default: pass = 1'b0;
        endcase
    end

    // Operation datapath plus the carry/overflow each op would produce.
    // C and V default to their held values so logic ops, MUL, MOV and
    // zero-length shifts leave them untouched.
    always_comb begin
        sum     = {1'b0, a} + {1'b0, b};
        diff    = {1'b0, a} - {1'b0, b};
        rsh_idx = iv - 5'd1;         // last bit out of a right shift
        lsh_idx = ~iv + 5'd1;        // 32-iv: last bit out of a left shift
        val     = bus.Result;
        c_n     = fc;
        v_n     = fv;
        wr_op   = 1'b0;
        mem_op  = 1'b0;
        flag_op = 1'b0;
        case (op_t'(bus.OpCode))
            OP_ADD: begin
                val = sum[31:0]; c_n = sum[32];
                v_n = (a[31] == b[31]) && (sum[31] != a[31]);
                wr_op = 1'b1; flag_op = 1'b1;
            end
            OP_SUB, OP_CMP: begin
                val = diff[31:0]; c_n = ~diff[32];
                v_n = (a[31] != b[31]) && (diff[31] != a[31]);
                wr_op = (bus.OpCode == OP_SUB); flag_op = 1'b1;
            end
            OP_MUL: begin val = a * b;  wr_op = 1'b1; flag_op = 1'b1; end
            OP_ORR: begin val = a | b;  wr_op = 1'b1; flag_op = 1'b1; end
            OP_AND: begin val = a & b;  wr_op = 1'b1; flag_op = 1'b1; end
            OP_EOR: begin val = a ^ b;  wr_op = 1'b1; flag_op = 1'b1; end
            OP_MOV: begin val = {16'h0, bus.IV_Mov}; wr_op = 1'b1; flag_op = 1'b1; end
            OP_LSR: begin
                val = a >> iv; if (iv != 5'd0) c_n = a[rsh_idx];
                wr_op = 1'b1; flag_op = 1'b1;
            end
            OP_LSL: begin
                val = a << iv; if (iv != 5'd0) c_n = a[lsh_idx];
                wr_op = 1'b1; flag_op = 1'b1;
            end
            OP_ROR: begin
                // Shift by 32 yields zero, so iv=0 collapses to a plain copy.
                val = (a >> iv) | (a << (6'd32 - {1'b0, iv}));
                if (iv != 5'd0) c_n = a[rsh_idx];
                wr_op = 1'b1; flag_op = 1'b1;
            end
            OP_ASR: begin
                val = $signed(a) >>> iv; if (iv != 5'd0) c_n = a[rsh_idx];
                wr_op = 1'b1; flag_op = 1'b1;
            end
            OP_LDR, OP_STR: begin val = a; mem_op = 1'b1; end
            default: ;
        endcase
    end

    // Commit decision: what gets written, which pulse fires, whether flags move.
    always_comb begin
        res_n  = bus.Result;
        flag_n = bus.Flag;
        we_n   = 1'b0;
        me_n   = 1'b0;
        if (pass) begin
            if (wr_op || mem_op) res_n = val;
            we_n = wr_op;
            me_n = mem_op;
            if (flag_op && (bus.S || bus.OpCode == OP_CMP))
                flag_n = {val[31], (val == 32'd0), c_n, v_n};
        end
    end

    // Output/flag registers; reset wins over everything.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            bus.Result        <= '0;
            bus.Flag          <= 4'b0000;
            bus.Write_en      <= 1'b0;
            bus.memory_enable <= 1'b0;
        end else begin
            bus.Result        <= res_n;
            bus.Flag          <= flag_n;
            bus.Write_en      <= we_n;
            bus.memory_enable <= me_n;
        end
    end
endmodule

// File: tb/tb_master_alu.sv
// Directed bench for master_alu: hand-computed results, flags and pulses.
module tb_master_alu;
    logic Clk = 1'b0;
    logic Reset = 1'b1;
    int   checks = 0;
    int   failures = 0;

    master_alu_if bus();

    master_alu dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus.slave)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [31:0] res, input logic [3:0] flg,
                           input logic we, input logic me);
        chk({tag, ".Result"}, bus.Result, res);
        chk({tag, ".Flag"}, {28'd0, bus.Flag}, {28'd0, flg});
        chk({tag, ".Write_en"}, {31'd0, bus.Write_en}, {31'd0, we});
        chk({tag, ".memory_enable"}, {31'd0, bus.memory_enable}, {31'd0, me});
    endtask

    // Present one instruction, clock it, and settle past the edge.
    task automatic step(input logic [3:0] cond, input logic [3:0] op, input logic s,
                        input logic [31:0] ra, input logic [31:0] rb,
                        input logic [4:0] iv, input logic [15:0] mv);
        bus.Cond = cond; bus.OpCode = op; bus.S = s;
        bus.Reg1 = ra; bus.Reg2 = rb; bus.IV_ShftRor = iv; bus.IV_Mov = mv;
        @(posedge Clk);
        #1;
    endtask

    initial begin
        bus.Cond = 4'hE; bus.OpCode = 4'hE; bus.S = 1'b0;
        bus.Reg1 = '0; bus.Reg2 = '0; bus.IV_ShftRor = '0; bus.IV_Mov = '0;

        step(4'hE, 4'h0, 1'b1, 32'd1, 32'd2, 5'd0, 16'h0);
        chk_all("reset", 32'h0, 4'b0000, 1'b0, 1'b0);
        Reset = 1'b0;

        step(4'hE, 4'h0, 1'b0, 32'd7, 32'd5, 5'd0, 16'h0);
        chk_all("add_nos", 32'd12, 4'b0000, 1'b1, 1'b0);
        step(4'hE, 4'h1, 1'b1, 32'd5, 32'd5, 5'd0, 16'h0);
        chk_all("sub_eq", 32'd0, 4'b0110, 1'b1, 1'b0);
        step(4'h0, 4'h6, 1'b0, 32'd0, 32'd0, 5'd0, 16'hBEEF);
        chk_all("eq_mov", 32'h0000BEEF, 4'b0110, 1'b1, 1'b0);
        step(4'h1, 4'h6, 1'b0, 32'd0, 32'd0, 5'd0, 16'h1234);
        chk_all("ne_mov_fail", 32'h0000BEEF, 4'b0110, 1'b0, 1'b0);
        step(4'hE, 4'h0, 1'b1, 32'h7FFFFFFF, 32'd1, 5'd0, 16'h0);
        chk_all("add_ovf", 32'h80000000, 4'b1001, 1'b1, 1'b0);
        step(4'hE, 4'h9, 1'b1, 32'd1, 32'd0, 5'd1, 16'h0);
        chk_all("ror1", 32'h80000000, 4'b1011, 1'b1, 1'b0);
        step(4'hE, 4'h8, 1'b1, 32'd3, 32'd0, 5'd0, 16'h0);
        chk_all("lsl0", 32'd3, 4'b0011, 1'b1, 1'b0);
        step(4'hE, 4'hC, 1'b0, 32'h10, 32'd0, 5'd0, 16'h0);
        chk_all("ldr", 32'h10, 4'b0011, 1'b0, 1'b1);
        step(4'hE, 4'hE, 1'b1, 32'h99, 32'h99, 5'd0, 16'h0);
        chk_all("nop", 32'h10, 4'b0011, 1'b0, 1'b0);
        step(4'hF, 4'h0, 1'b1, 32'd1, 32'd1, 5'd0, 16'h0);
        chk_all("never_add", 32'h10, 4'b0011, 1'b0, 1'b0);
        step(4'hF, 4'hC, 1'b0, 32'h20, 32'd0, 5'd0, 16'h0);
        chk_all("never_ldr", 32'h10, 4'b0011, 1'b0, 1'b0);
        step(4'hE, 4'hA, 1'b0, 32'd3, 32'd5, 5'd0, 16'h0);
        chk_all("cmp_lt", 32'h10, 4'b1000, 1'b0, 1'b0);
        step(4'hB, 4'h6, 1'b0, 32'd0, 32'd0, 5'd0, 16'h0055);
        chk_all("lt_mov", 32'h55, 4'b1000, 1'b1, 1'b0);
        step(4'hA, 4'h6, 1'b0, 32'd0, 32'd0, 5'd0, 16'h0066);
        chk_all("ge_mov_fail", 32'h55, 4'b1000, 1'b0, 1'b0);
        step(4'hE, 4'h7, 1'b1, 32'h80000001, 32'd0, 5'd1, 16'h0);
        chk_all("lsr1", 32'h40000000, 4'b0010, 1'b1, 1'b0);
        step(4'hE, 4'hB, 1'b1, 32'h80000000, 32'd0, 5'd4, 16'h0);
        chk_all("asr4", 32'hF8000000, 4'b1000, 1'b1, 1'b0);
        step(4'hE, 4'h2, 1'b0, 32'd6, 32'hFFFFFFF9, 5'd0, 16'h0);
        chk_all("mul", 32'hFFFFFFD6, 4'b1000, 1'b1, 1'b0);
        step(4'hE, 4'h5, 1'b1, 32'hFF, 32'hFF, 5'd0, 16'h0);
        chk_all("eor_z", 32'h0, 4'b0100, 1'b1, 1'b0);
        step(4'hE, 4'h4, 1'b0, 32'hF0F0, 32'h0FF0, 5'd0, 16'h0);
        chk_all("and", 32'h00F0, 4'b0100, 1'b1, 1'b0);
        step(4'hE, 4'h3, 1'b0, 32'hF000, 32'h000F, 5'd0, 16'h0);
        chk_all("orr", 32'hF00F, 4'b0100, 1'b1, 1'b0);
        step(4'hE, 4'hD, 1'b0, 32'h44, 32'd0, 5'd0, 16'h0);
        chk_all("str", 32'h44, 4'b0100, 1'b0, 1'b1);

        Reset = 1'b1;
        step(4'hE, 4'h0, 1'b1, 32'd9, 32'd9, 5'd0, 16'h0);
        chk_all("reset_mid", 32'h0, 4'b0000, 1'b0, 1'b0);
        Reset = 1'b0;
        step(4'h8, 4'h6, 1'b0, 32'd0, 32'd0, 5'd0, 16'h0077);
        chk_all("hi_fail", 32'h0, 4'b0000, 1'b0, 1'b0);
        step(4'hE, 4'h8, 1'b1, 32'h10000001, 32'd0, 5'd4, 16'h0);
        chk_all("lsl4", 32'h00000010, 4'b0010, 1'b1, 1'b0);
        step(4'hE, 4'h1, 1'b0, 32'd2, 32'd5, 5'd0, 16'h0);
        chk_all("sub_nos", 32'hFFFFFFFD, 4'b0010, 1'b1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
